// File: rtl/spi_reg_pkg.sv
// Shared types and register-map constants for the SPI register bank.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    WR_DATA = 2'd2,
    RD_DATA = 2'd3
  } state_e;

  localparam int CMD_WR_BIT   = 7;
  localparam int REG_ID       = 0;
  localparam int REG_FRAMES   = 1;
  localparam int FIRST_RW_REG = 2;

endpackage

// File: rtl/spi_reg_file.sv
// Register storage with the read-only ID/frame-counter overlay and the read mux.
module spi_reg_file
  import spi_reg_pkg::*;
#(
  parameter int         NUM_REGS  = 8,
  parameter logic [7:0] DEVICE_ID = 8'hA5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we_i,
  input  logic [$clog2(NUM_REGS)-1:0] waddr_i,
  input  logic [7:0]                  wdata_i,
  input  logic                        frame_inc_i,
  input  logic [$clog2(NUM_REGS)-1:0] raddr_i,
  output logic [7:0]                  rdata_o,
  output logic [NUM_REGS*8-1:0]       regs_out_o
);

  localparam int AW = $clog2(NUM_REGS);

  logic [7:0] rw_q [NUM_REGS];
  logic [7:0] frame_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) rw_q[i] <= '0;
      frame_q <= '0;
    end else begin
      if (we_i) rw_q[waddr_i] <= wdata_i;
      if (frame_inc_i) frame_q <= frame_q + 8'd1;
    end
  end

  always_comb begin
    rdata_o = rw_q[raddr_i];
    if (raddr_i == AW'(REG_ID)) begin
      rdata_o = DEVICE_ID;
    end else if (raddr_i == AW'(REG_FRAMES)) begin
      rdata_o = frame_q;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    if (g == REG_ID) begin : g_id
      assign regs_out_o[8*g +: 8] = DEVICE_ID;
    end else if (g == REG_FRAMES) begin : g_frames
      assign regs_out_o[8*g +: 8] = frame_q;
    end else begin : g_rw
      assign regs_out_o[8*g +: 8] = rw_q[g];
    end
  end

endmodule

// File: rtl/spi_reg_bank.sv
// Turns SPI frames (command byte + auto-incrementing data bytes) into register
// reads/writes and supplies the byte the slave shifts out on the next transfer.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int         NUM_REGS  = 8,
  parameter logic [7:0] DEVICE_ID = 8'hA5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cs_active,
  input  logic                        rx_valid,
  input  logic [7:0]                  rx_byte,
  output logic [7:0]                  tx_byte,
  output logic [NUM_REGS*8-1:0]       regs_out,
  output logic                        wr_pulse,
  output logic [$clog2(NUM_REGS)-1:0] wr_addr,
  output state_e                      state_dbg
);

  localparam int AW = $clog2(NUM_REGS);

  // A byte is consumed only when rx_valid and cs_active are both high in the
  // same cycle; there is no backpressure, every such byte is taken.
  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d, addr_inc, rd_addr;
  logic [7:0]      tx_q, tx_d, rd_data;
  logic            wr_pulse_q, wr_pulse_d, we, frame_inc;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;

  assign addr_inc = addr_q + AW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      tx_q       <= DEVICE_ID;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tx_d       = tx_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    we         = 1'b0;
    frame_inc  = 1'b0;
    rd_addr    = addr_inc;
    if (state_q != IDLE && !cs_active) begin
      // Frame end; leaving CMD means no byte was processed, so it is not counted.
      state_d   = IDLE;
      addr_d    = '0;
      tx_d      = DEVICE_ID;
      frame_inc = (state_q != CMD);
    end else begin
      case (state_q)
        IDLE: begin
          addr_d = '0;
          tx_d   = DEVICE_ID;
          if (cs_active) state_d = CMD;
        end
        CMD: if (rx_valid) begin
          addr_d = rx_byte[AW-1:0];
          if (rx_byte[CMD_WR_BIT]) begin
            state_d = WR_DATA;
            tx_d    = rx_byte;
          end else begin
            state_d = RD_DATA;
            rd_addr = rx_byte[AW-1:0];
            tx_d    = rd_data;
          end
        end
        WR_DATA: if (rx_valid) begin
          if (addr_q >= AW'(FIRST_RW_REG)) begin
            we         = 1'b1;
            wr_pulse_d = 1'b1;
            wr_addr_d  = addr_q;
          end
          addr_d = addr_inc;
          tx_d   = rx_byte;
        end
        RD_DATA: if (rx_valid) begin
          addr_d = addr_inc;
          tx_d   = rd_data;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  spi_reg_file #(
    .NUM_REGS  (NUM_REGS),
    .DEVICE_ID (DEVICE_ID)
  ) u_reg_file (
    .clk         (clk),
    .rst_n       (rst_n),
    .we_i        (we),
    .waddr_i     (addr_q),
    .wdata_i     (rx_byte),
    .frame_inc_i (frame_inc),
    .raddr_i     (rd_addr),
    .rdata_o     (rd_data),
    .regs_out_o  (regs_out)
  );

  assign tx_byte   = tx_q;
  assign wr_pulse  = wr_pulse_q;
  assign wr_addr   = wr_addr_q;
  assign state_dbg = state_q;

endmodule
